// File: rtl/core_l1i_l2_flush_ctrl_pkg.sv
// Shared cache-control package.
// Holds the flush sequencer state encoding so the top level and any
// perf counters decode flush_state with the same names.
package core_l1i_l2_flush_ctrl_pkg;

  // 3-bit encoding; values 5..7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    FS_IDLE         = 3'd0,
    FS_WAIT_L1D_L1I = 3'd1,
    FS_GOT_L1D      = 3'd2,
    FS_GOT_L1I      = 3'd3,
    FS_FLUSH_L2     = 3'd4
  } flush_state_t;

endpackage

// File: rtl/core_l1i_l2_flush_ctrl.sv
// Cache-flush sequencer between the core, L1I, L1D and the unified L2.
// Accepts a flush request for either or both L1s, waits for every requested
// L1 to report completion, issues one L2 flush request and waits for the L2
// to finish. The core is held in flush mode for the whole sequence.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   flush_req_l1i/l1d   core flush requests (pulses, sampled in IDLE only)
//   l1i/l1d/l2_flush_complete   completion pulses from the caches
//   in_flush_mode       high while a sequence is in progress
//   flush_l2            one-cycle request to the L2 to start flushing
//   flush_state         current state encoding (debug / perf)
//   flush_count         completed sequences, wraps modulo 2^CNT_W
//
// Signalling: every input is a single-cycle pulse with no back-pressure.
// A pulse is acted on only in a state that is listening for it; anything
// else (requests outside IDLE, completions in IDLE or for an L1 already
// done) is dropped, never queued.
module core_l1i_l2_flush_ctrl
  import core_l1i_l2_flush_ctrl_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_req_l1i,
  input  logic             flush_req_l1d,
  input  logic             l1i_flush_complete,
  input  logic             l1d_flush_complete,
  input  logic             l2_flush_complete,
  output logic             in_flush_mode,
  output logic             flush_l2,
  output logic [2:0]       flush_state,
  output logic [CNT_W-1:0] flush_count
);

  flush_state_t     state_q, state_d;
  logic             mode_q, mode_d;
  logic             l2_req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    l2_req_d = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      FS_IDLE: begin
        // A single request means the other L1 is treated as already done,
        // so the "GOT" state named after the other cache is entered.
        if (flush_req_l1i && flush_req_l1d) begin
          state_d = FS_WAIT_L1D_L1I;
          mode_d  = 1'b1;
        end else if (flush_req_l1i) begin
          state_d = FS_GOT_L1D;
          mode_d  = 1'b1;
        end else if (flush_req_l1d) begin
          state_d = FS_GOT_L1I;
          mode_d  = 1'b1;
        end
      end
      FS_WAIT_L1D_L1I: begin
        if (l1i_flush_complete && l1d_flush_complete) begin
          state_d  = FS_FLUSH_L2;
          l2_req_d = 1'b1;
        end else if (l1d_flush_complete) begin
          state_d = FS_GOT_L1D;
        end else if (l1i_flush_complete) begin
          state_d = FS_GOT_L1I;
        end
      end
      FS_GOT_L1D: begin
        if (l1i_flush_complete) begin
          state_d  = FS_FLUSH_L2;
          l2_req_d = 1'b1;
        end
      end
      FS_GOT_L1I: begin
        if (l1d_flush_complete) begin
          state_d  = FS_FLUSH_L2;
          l2_req_d = 1'b1;
        end
      end
      FS_FLUSH_L2: begin
        // The L2 may complete in the very cycle flush_l2 is high.
        if (l2_flush_complete) begin
          state_d = FS_IDLE;
          mode_d  = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = FS_IDLE;
        mode_d  = 1'b0;
      end
    endcase
  end

  // flush_l2 registers the entry-into-FLUSH_L2 condition, so it is high
  // exactly for the first cycle spent in FLUSH_L2.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FS_IDLE;
      mode_q   <= 1'b0;
      flush_l2 <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      flush_l2 <= l2_req_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_flush_mode = mode_q;
  assign flush_state   = state_q;
  assign flush_count   = cnt_q;

endmodule

// File: tb/tb_core_l1i_l2_flush_ctrl.sv
module tb_core_l1i_l2_flush_ctrl;

  localparam int CNT_W = 64;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             flush_req_l1i, flush_req_l1d;
  logic             l1i_flush_complete, l1d_flush_complete, l2_flush_complete;
  logic             in_flush_mode, flush_l2;
  logic [2:0]       flush_state;
  logic [CNT_W-1:0] flush_count;

  always #5 clk = ~clk;

  core_l1i_l2_flush_ctrl #(.CNT_W(CNT_W)) dut (
    .clk                (clk),
    .reset              (reset),
    .flush_req_l1i      (flush_req_l1i),
    .flush_req_l1d      (flush_req_l1d),
    .l1i_flush_complete (l1i_flush_complete),
    .l1d_flush_complete (l1d_flush_complete),
    .l2_flush_complete  (l2_flush_complete),
    .in_flush_mode      (in_flush_mode),
    .flush_l2           (flush_l2),
    .flush_state        (flush_state),
    .flush_count        (flush_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // Tracks which L1s still owe a completion and whether the sequence is
  // waiting on the L2; the reported state is derived from those facts.
  bit               m_active, m_pend_i, m_pend_d, m_l2_phase, m_l2_first;
  logic [CNT_W-1:0] m_count;

  task automatic model_step(input bit ri, rd, ci, cd, c2, rs);
    if (rs) begin
      m_active = 0; m_pend_i = 0; m_pend_d = 0;
      m_l2_phase = 0; m_l2_first = 0; m_count = '0;
    end else begin
      m_l2_first = 0;
      if (!m_active) begin
        if (ri || rd) begin
          m_active = 1; m_pend_i = ri; m_pend_d = rd;
        end
      end else if (!m_l2_phase) begin
        if (ci) m_pend_i = 0;
        if (cd) m_pend_d = 0;
        if (!m_pend_i && !m_pend_d) begin
          m_l2_phase = 1; m_l2_first = 1;
        end
      end else if (c2) begin
        m_active = 0; m_l2_phase = 0; m_count = m_count + 1;
      end
    end
  endtask

  function automatic logic [2:0] model_state();
    if (!m_active)              return 3'd0;
    if (m_l2_phase)             return 3'd4;
    if (m_pend_i && m_pend_d)   return 3'd1;
    if (m_pend_i)               return 3'd2;  // L1D already done
    return 3'd3;                              // L1I already done
  endfunction

  // ---------------- driver ----------------
  // Inputs change #1 after the rising edge; outputs are sampled #1 after
  // the next rising edge, once the registered values have settled.
  task automatic drive_cycle(input bit ri, rd, ci, cd, c2, rs);
    flush_req_l1i      = ri;
    flush_req_l1d      = rd;
    l1i_flush_complete = ci;
    l1d_flush_complete = cd;
    l2_flush_complete  = c2;
    reset              = rs;
    @(posedge clk);
    #1;
    model_step(ri, rd, ci, cd, c2, rs);
  endtask

  task automatic check(input string name, input logic [CNT_W-1:0] act, exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input bit md,
                           input bit l2, input logic [CNT_W-1:0] cnt);
    check({tag, ".state"}, CNT_W'(flush_state), CNT_W'(st));
    check({tag, ".mode"},  CNT_W'(in_flush_mode), CNT_W'(md));
    check({tag, ".l2req"}, CNT_W'(flush_l2), CNT_W'(l2));
    check({tag, ".count"}, flush_count, cnt);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit ri, rd, ci, cd, c2, rs;
    logic [2:0] st;
    bit md, l2;
    int cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit ri, rd, ci, cd, c2, rs,
                     input logic [2:0] st, input bit md, l2, input int cnt);
    vec_t v;
    v.ri = ri; v.rd = rd; v.ci = ci; v.cd = cd; v.c2 = c2; v.rs = rs;
    v.st = st; v.md = md; v.l2 = l2; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    flush_req_l1i = 0; flush_req_l1d = 0;
    l1i_flush_complete = 0; l1d_flush_complete = 0; l2_flush_complete = 0;
    reset = 1;

    //   ri rd ci cd c2 rs  state mode l2 cnt
    // both requests, L1D first then L1I, then L2
    add(1, 1, 0, 0, 0, 0,  1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,  2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  2, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0,  4, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0,  4, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  4, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,  0, 0, 0, 1);
    // L1I-only request; stray L1D complete ignored; request during FLUSH_L2 dropped
    add(1, 0, 0, 0, 0, 0,  2, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0,  2, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0,  4, 1, 1, 1);
    add(1, 0, 0, 0, 0, 0,  4, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0,  0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 2);
    // L1D-only request; L2 completes in the same cycle flush_l2 is high
    add(0, 1, 0, 0, 0, 0,  3, 1, 0, 2);
    add(0, 0, 1, 0, 0, 0,  3, 1, 0, 2);
    add(0, 0, 0, 1, 0, 0,  4, 1, 1, 2);
    add(0, 0, 0, 0, 1, 0,  0, 0, 0, 3);
    // stray completes in IDLE
    add(0, 0, 1, 1, 1, 0,  0, 0, 0, 3);
    // minimum sequence: simultaneous L1 completes
    add(1, 1, 0, 0, 0, 0,  1, 1, 0, 3);
    add(0, 0, 1, 1, 0, 0,  4, 1, 1, 3);
    add(0, 0, 0, 0, 0, 0,  4, 1, 0, 3);
    add(0, 0, 0, 0, 1, 0,  0, 0, 0, 4);
    // reset mid-sequence in GOT_L1I, then the pending completion is ignored
    add(0, 1, 0, 0, 0, 0,  3, 1, 0, 4);
    add(0, 0, 0, 0, 0, 1,  0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

    // reset held for two cycles
    drive_cycle(0, 0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 0, 1);
    check_all("reset", 3'd0, 1'b0, 1'b0, '0);

    foreach (vecs[i]) begin
      drive_cycle(vecs[i].ri, vecs[i].rd, vecs[i].ci, vecs[i].cd, vecs[i].c2, vecs[i].rs);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].md, vecs[i].l2,
                CNT_W'(vecs[i].cnt));
    end

    // ---------------- randomized run vs. model ----------------
    for (int c = 0; c < 3000; c++) begin
      bit ri, rd, ci, cd, c2, rs;
      ri = ($urandom_range(3, 0) == 0);
      rd = ($urandom_range(3, 0) == 0);
      ci = ($urandom_range(2, 0) == 0);
      cd = ($urandom_range(2, 0) == 0);
      c2 = ($urandom_range(2, 0) == 0);
      rs = ($urandom_range(199, 0) == 0);
      drive_cycle(ri, rd, ci, cd, c2, rs);
      check_all($sformatf("rand%0d", c), model_state(), m_active, m_l2_first, m_count);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_l1i_l2_flush_ctrl.md
# core_l1i_l2_flush_ctrl

Cache-flush sequencer between the core, the L1 instruction cache, the L1 data cache and the unified L2. It accepts flush requests from the core for either or both L1s and waits until both L1s report completion. It then issues a single L2 flush and waits for L2 completion. While this is in progress it holds the core in flush mode.

## Interface
Parameters:
- CNT_W, default 64, width of the completed-flush counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- flush_req_l1i  in  1  core requests L1I flush (pulse; sampled in IDLE only).
- flush_req_l1d  in  1  core requests L1D flush (pulse; sampled in IDLE only).
- l1i_flush_complete  in  1  L1I finished flushing (pulse).
- l1d_flush_complete  in  1  L1D finished flushing (pulse).
- l2_flush_complete  in  1  L2 finished flushing (pulse).
- in_flush_mode  out  1  flush sequence active.
- flush_l2  out  1  one-cycle request to L2 to begin its flush.
- flush_state  out  3  current state encoding, for debug and perf.
- flush_count  out  CNT_W  number of completed flush sequences.

## Operation
States and encodings: IDLE=0, WAIT_L1D_L1I=1, GOT_L1D=2, GOT_L1I=3, FLUSH_L2=4.

Transitions, evaluated each cycle:
- IDLE:
  - both requests high → WAIT_L1D_L1I.
  - only flush_req_l1i → GOT_L1D (L1D treated as already done).
  - only flush_req_l1d → GOT_L1I.
  - each of these sets in_flush_mode.
  - no request → stay in IDLE.
  - completion inputs are ignored in IDLE.
- WAIT_L1D_L1I:
  - only l1d complete → GOT_L1D.
  - only l1i complete → GOT_L1I.
  - both complete → FLUSH_L2, with an L2 request.
  - neither → stay.
- GOT_L1D: l1i_flush_complete → FLUSH_L2, with an L2 request. Other inputs are ignored.
- GOT_L1I: l1d_flush_complete → FLUSH_L2, with an L2 request. Other inputs are ignored.
- FLUSH_L2: l2_flush_complete → IDLE, clear in_flush_mode, increment flush_count (wraps modulo 2^CNT_W).
- Encodings 5–7 → IDLE with in_flush_mode cleared. No L2 request is issued.

Other rules:
- Flush requests arriving outside IDLE are dropped, not queued.
- flush_l2 is the registered form of the transition-to-FLUSH_L2 condition. It is therefore high exactly during the first cycle spent in FLUSH_L2.
- Reset values: state IDLE, in_flush_mode=0, flush_l2=0, flush_count=0. Reset asserted mid-sequence aborts the sequence immediately with these values. No L2 request is issued.

## Timing
- State, in_flush_mode, flush_l2 and flush_count are all registered. Next-state logic is combinational.
- in_flush_mode rises one cycle after the accepted request.
- Completions are honoured from the first cycle of the waiting state onward.
- l2_flush_complete is accepted in the same cycle flush_l2 is high.
- in_flush_mode falls, and flush_count increments, one cycle after l2_flush_complete.
- Minimum sequence: request at cycle 0. Both L1 completes at cycle 1. flush_l2=1 at cycle 2. l2 complete at cycle 2. in_flush_mode=0 at cycle 3.

## Structure
- Put the flush_state_t enum (3-bit, encodings above) in a shared cache package, for reuse by the top level and perf counters.
- Single module, no sub-modules.
- One always_ff for the state registers and one always_comb for next-state logic.

## Test plan
- Reset: assert reset 2 cycles → state=0, in_flush_mode=0, flush_l2=0, flush_count=0.
- Both-request path: both reqs at c0 → state=1 at c1. l1d complete at c3 → state=2 at c4. l1i complete at c6 → state=4 and flush_l2=1 at c7, flush_l2=0 at c8. l2 complete at c9 → state=0, in_flush_mode=0, flush_count=1 at c10.
- Single requests:
  - flush_req_l1i only → state=2. l1d complete ignored. l1i complete → FLUSH_L2.
  - flush_req_l1d only → state=3, then proceeds symmetrically.
- Simultaneous completes in WAIT_L1D_L1I → direct to state=4 next cycle with flush_l2=1.
- Requests and completes while active or in IDLE:
  - flush_req_l1i during FLUSH_L2 → no effect; exactly one flush_count increment.
  - stray completes in IDLE → state stays 0.
- Reset mid-sequence: reset in GOT_L1I → state=0, in_flush_mode=0 next cycle, flush_l2 never asserted.
